// File: rtl/wam_score.sv
// Whack-a-mole game logic: strike detection, hit judging, packed-BCD score,
// difficulty level and countdown feeding the digital-tube display stage.
module wam_score #(
    parameter int GAME_SEC   = 60,
    parameter bit PENALTY_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        tick_1hz,
    input  logic [7:0]  holes,
    input  logic [7:0]  sw,
    output logic [11:0] score,
    output logic [3:0]  hrdn,
    output logic [7:0]  whack,
    output logic [7:0]  time_left,
    output logic        over
);

    localparam logic [7:0] GAME_T = 8'(GAME_SEC);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    state_t      state_r, state_nx_s;
    logic [7:0]  sw_q_r, pending_r, whack_r, time_r;
    logic [11:0] score_r;
    logic [3:0]  hrdn_r;
    logic        over_r;

    logic [7:0]  new_s, served_s, pending_nx_s, whack_nx_s, time_nx_s;
    logic [11:0] score_nx_s;
    logic [3:0]  hrdn_nx_s;
    logic        over_nx_s;

    // Saturating BCD increment; digits stay within 0..9.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v == 12'h999) begin
            r = v;
        end else if (v[3:0] != 4'd9) begin
            r[3:0] = v[3:0] + 4'd1;
        end else if (v[7:4] != 4'd9) begin
            r = {v[11:8], v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[11:8] + 4'd1, 8'h00};
        end
        return r;
    endfunction

    function automatic logic [11:0] bcd_dec(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v == 12'h000) begin
            r = v;
        end else if (v[3:0] != 4'd0) begin
            r[3:0] = v[3:0] - 4'd1;
        end else if (v[7:4] != 4'd0) begin
            r = {v[11:8], v[7:4] - 4'd1, 4'd9};
        end else begin
            r = {v[11:8] - 4'd1, 8'h99};
        end
        return r;
    endfunction

    function automatic logic [3:0] level_of(input logic [11:0] s);
        logic [3:0] l;
        case (s[11:4])
            8'h00:        l = 4'd1;
            8'h01:        l = 4'd2;
            8'h02, 8'h03: l = 4'd3;
            default:      l = 4'd4;
        endcase
        return l;
    endfunction

    assign new_s    = sw & ~sw_q_r;
    assign served_s = pending_r & (~pending_r + 8'd1);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: state_nx_s = start ? ST_PLAY : ST_IDLE;
            ST_PLAY: state_nx_s = (tick_1hz && (time_r == 8'd1)) ? ST_OVER : ST_PLAY;
            ST_OVER: state_nx_s = start ? ST_PLAY : ST_OVER;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // FSM outputs: strike service, score, timer and level next values
    always_comb begin
        pending_nx_s = 8'h00;
        score_nx_s   = score_r;
        whack_nx_s   = 8'h00;
        time_nx_s    = time_r;
        if (state_r == ST_PLAY) begin
            if (state_nx_s == ST_OVER) begin
                pending_nx_s = 8'h00;
            end else begin
                pending_nx_s = (pending_r | new_s) & ~served_s;
            end
            if ((served_s & holes) != 8'h00) begin
                score_nx_s = bcd_inc(score_r);
                whack_nx_s = served_s;
            end else if ((served_s != 8'h00) && PENALTY_EN) begin
                score_nx_s = bcd_dec(score_r);
            end else begin
                score_nx_s = score_r;
            end
            if (tick_1hz) begin
                time_nx_s = time_r - 8'd1;
            end else begin
                time_nx_s = time_r;
            end
        end else if (state_nx_s == ST_PLAY) begin
            score_nx_s = 12'h000;
            time_nx_s  = GAME_T;
        end else begin
            score_nx_s = score_r;
        end
        // Level lags the score by one register; a fresh game shows level 1 at once.
        case (state_nx_s)
            ST_IDLE: hrdn_nx_s = 4'd0;
            ST_OVER: hrdn_nx_s = 4'hF;
            ST_PLAY: hrdn_nx_s = (state_r == ST_PLAY) ? level_of(score_r) : 4'd1;
            default: hrdn_nx_s = 4'd0;
        endcase
        over_nx_s = (state_nx_s == ST_OVER);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        sw_q_r <= sw;
        if (rst) begin
            pending_r <= 8'h00;
            score_r   <= 12'h000;
            whack_r   <= 8'h00;
            time_r    <= GAME_T;
            hrdn_r    <= 4'd0;
            over_r    <= 1'b0;
        end else begin
            pending_r <= pending_nx_s;
            score_r   <= score_nx_s;
            whack_r   <= whack_nx_s;
            time_r    <= time_nx_s;
            hrdn_r    <= hrdn_nx_s;
            over_r    <= over_nx_s;
        end
    end

    assign score     = score_r;
    assign hrdn      = hrdn_r;
    assign whack     = whack_r;
    assign time_left = time_r;
    assign over      = over_r;

endmodule

// File: tb/tb_wam_score.sv
// Self-checking bench for wam_score: directed scenarios plus a randomized run,
// all judged against an integer-score behavioural model of the game.
module tb_wam_score;

    localparam int GAME = 3;

    logic        clk = 1'b0;
    logic        rst, start, tick_1hz;
    logic [7:0]  holes, sw;
    logic [11:0] score;
    logic [3:0]  hrdn;
    logic [7:0]  whack, time_left;
    logic        over;

    int checks = 0;
    int failures = 0;

    // Model: mode 0=idle 1=play 2=over, score as a plain integer
    int         m_mode, m_score, m_time, m_hrdn;
    logic [7:0] m_pend, m_prev_sw, m_whack;
    logic       m_over;
    logic [32:0] exp_v, act_v;

    wam_score #(.GAME_SEC(GAME), .PENALTY_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .tick_1hz(tick_1hz),
        .holes(holes), .sw(sw), .score(score), .hrdn(hrdn),
        .whack(whack), .time_left(time_left), .over(over)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int lvl(input int s);
        return (s < 10) ? 1 : (s < 20) ? 2 : (s < 40) ? 3 : 4;
    endfunction

    // Advance the model by one clock using the current inputs, then clock the DUT.
    task automatic step();
        logic [7:0] edges, served;
        int old_score, old_mode;
        if (rst) begin
            m_mode = 0; m_score = 0; m_time = GAME; m_pend = 8'h00;
            m_whack = 8'h00; m_hrdn = 0; m_over = 1'b0; m_prev_sw = sw;
        end else begin
            edges = sw & ~m_prev_sw;
            m_prev_sw = sw;
            m_whack = 8'h00;
            old_score = m_score;
            old_mode = m_mode;
            if (m_mode == 1) begin
                served = 8'h00;
                for (int i = 0; i < 8; i++) begin
                    if (m_pend[i] && served == 8'h00) begin
                        served[i] = 1'b1;
                        if (holes[i]) begin
                            if (m_score < 999) m_score++;
                            m_whack[i] = 1'b1;
                        end else if (m_score > 0) begin
                            m_score--;
                        end
                    end
                end
                m_pend = (m_pend | edges) & ~served;
                if (tick_1hz) begin
                    m_time--;
                    if (m_time == 0) begin
                        m_mode = 2;
                        m_pend = 8'h00;
                    end
                end
            end else begin
                m_pend = 8'h00;
                if (start) begin
                    m_mode = 1; m_score = 0; m_time = GAME;
                end
            end
            m_over = (m_mode == 2);
            m_hrdn = (m_mode == 0) ? 0 : (m_mode == 2) ? 15 : (old_mode != 1) ? 1 : lvl(old_score);
        end
        @(posedge clk);
        #1;
        exp_v = {to_bcd(m_score), 4'(m_hrdn), m_whack, 8'(m_time), m_over};
        act_v = {score, hrdn, whack, time_left, over};
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; tick_1hz = 1'b0; holes = 8'h00; sw = 8'h00;
        step(); step();
        checks++; if (score !== 12'h000) begin failures++; $display("FAIL reset_score got=%h exp=000", score); end
        checks++; if (hrdn !== 4'd0) begin failures++; $display("FAIL reset_hrdn got=%h exp=0", hrdn); end
        checks++; if (whack !== 8'h00) begin failures++; $display("FAIL reset_whack got=%h exp=00", whack); end
        checks++; if (time_left !== 8'd3) begin failures++; $display("FAIL reset_time got=%0d exp=3", time_left); end
        checks++; if (over !== 1'b0) begin failures++; $display("FAIL reset_over got=%b exp=0", over); end
        rst = 1'b0;
    endtask

    task automatic test_single_hit();
        start = 1'b1; step(); start = 1'b0;
        checks++; if (hrdn !== 4'd1 || time_left !== 8'd3) begin failures++; $display("FAIL start_play got hrdn=%h time=%0d exp hrdn=1 time=3", hrdn, time_left); end
        holes = 8'h04; sw = 8'h04; step();
        checks++; if (whack !== 8'h00) begin failures++; $display("FAIL hit_early_whack got=%h exp=00", whack); end
        step();
        checks++; if (whack !== 8'h04 || score !== 12'h001) begin failures++; $display("FAIL hit_result got whack=%h score=%h exp whack=04 score=001", whack, score); end
        step();
        checks++; if (whack !== 8'h00 || hrdn !== 4'd1) begin failures++; $display("FAIL hit_after got whack=%h hrdn=%h exp whack=00 hrdn=1", whack, hrdn); end
        sw = 8'h00; step(); step();
        checks++; if (score !== 12'h001) begin failures++; $display("FAIL held_sw_once got=%h exp=001", score); end
    endtask

    task automatic test_bcd_carry_saturate();
        rst = 1'b1; step(); rst = 1'b0; start = 1'b1; step(); start = 1'b0;
        holes = 8'hFF;
        for (int k = 0; k < 9; k++) begin sw = 8'h01; step(); sw = 8'h00; step(); end
        checks++; if (score !== 12'h009) begin failures++; $display("FAIL bcd_nine got=%h exp=009", score); end
        sw = 8'h01; step(); sw = 8'h00; step();
        checks++; if (score !== 12'h010) begin failures++; $display("FAIL bcd_carry got=%h exp=010", score); end
        step();
        checks++; if (hrdn !== 4'd2) begin failures++; $display("FAIL level_two got=%h exp=2", hrdn); end
        for (int k = 10; k < 1000; k++) begin
            sw = 8'h01; step(); sw = 8'h00; step();
            checks++; if (act_v !== exp_v) begin failures++; $display("FAIL bcd_run k=%0d got=%h exp=%h", k, act_v, exp_v); end
        end
        checks++; if (score !== 12'h999) begin failures++; $display("FAIL bcd_reach999 got=%h exp=999", score); end
        sw = 8'h01; step(); sw = 8'h00; step();
        checks++; if (whack !== 8'h01 || score !== 12'h999) begin failures++; $display("FAIL saturate got whack=%h score=%h exp whack=01 score=999", whack, score); end
        step();
        checks++; if (hrdn !== 4'd4) begin failures++; $display("FAIL level_four got=%h exp=4", hrdn); end
    endtask

    task automatic test_penalty();
        rst = 1'b1; step(); rst = 1'b0; start = 1'b1; step(); start = 1'b0;
        holes = 8'hFF;
        for (int k = 0; k < 10; k++) begin sw = 8'h01; step(); sw = 8'h00; step(); end
        holes = 8'h00;
        sw = 8'h01; step(); sw = 8'h00; step();
        checks++; if (score !== 12'h009 || whack !== 8'h00) begin failures++; $display("FAIL penalty_borrow got score=%h whack=%h exp score=009 whack=00", score, whack); end
        for (int k = 0; k < 9; k++) begin sw = 8'h01; step(); sw = 8'h00; step(); end
        checks++; if (score !== 12'h000) begin failures++; $display("FAIL penalty_zero got=%h exp=000", score); end
        sw = 8'h01; step(); sw = 8'h00; step();
        checks++; if (score !== 12'h000 || whack !== 8'h00) begin failures++; $display("FAIL penalty_floor got score=%h whack=%h exp score=000 whack=00", score, whack); end
    endtask

    task automatic test_back_to_back();
        holes = 8'hFF; sw = 8'h00; step();
        sw = 8'h81; step(); step();
        checks++; if (whack !== 8'h01) begin failures++; $display("FAIL b2b_first got=%h exp=01", whack); end
        step();
        checks++; if (whack !== 8'h80 || score !== 12'h002) begin failures++; $display("FAIL b2b_second got whack=%h score=%h exp whack=80 score=002", whack, score); end
        sw = 8'h00; step();
        checks++; if (whack !== 8'h00) begin failures++; $display("FAIL b2b_end got=%h exp=00", whack); end
    endtask

    task automatic test_timer_over();
        rst = 1'b1; step(); rst = 1'b0;
        start = 1'b1; tick_1hz = 1'b1; step(); start = 1'b0; tick_1hz = 1'b0;
        checks++; if (time_left !== 8'd3 || hrdn !== 4'd1) begin failures++; $display("FAIL idle_start_tick got time=%0d hrdn=%h exp time=3 hrdn=1", time_left, hrdn); end
        for (int t = 2; t >= 0; t--) begin
            tick_1hz = 1'b1; step(); tick_1hz = 1'b0;
            checks++; if (time_left !== 8'(t)) begin failures++; $display("FAIL countdown got=%0d exp=%0d", time_left, t); end
        end
        checks++; if (over !== 1'b1 || hrdn !== 4'hF) begin failures++; $display("FAIL over_entry got over=%b hrdn=%h exp over=1 hrdn=f", over, hrdn); end
        holes = 8'hFF; sw = 8'h01; step(); sw = 8'h00; step(); step();
        checks++; if (score !== 12'h000 || whack !== 8'h00 || time_left !== 8'd0) begin failures++; $display("FAIL over_frozen got score=%h whack=%h time=%0d exp 000/00/0", score, whack, time_left); end
        start = 1'b1; tick_1hz = 1'b1; step(); start = 1'b0; tick_1hz = 1'b0;
        checks++; if (over !== 1'b0 || time_left !== 8'd3 || score !== 12'h000) begin failures++; $display("FAIL restart got over=%b time=%0d score=%h exp 0/3/000", over, time_left, score); end
    endtask

    task automatic test_reset_mid_game();
        holes = 8'hFF; sw = 8'h01; step(); sw = 8'h00; step(); step();
        checks++; if (score !== 12'h001) begin failures++; $display("FAIL mid_pre_score got=%h exp=001", score); end
        sw = 8'h0C; step();
        rst = 1'b1; step(); rst = 1'b0;
        checks++; if (score !== 12'h000 || whack !== 8'h00 || time_left !== 8'd3 || hrdn !== 4'd0 || over !== 1'b0) begin failures++; $display("FAIL mid_reset got score=%h whack=%h time=%0d hrdn=%h over=%b", score, whack, time_left, hrdn, over); end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (whack !== 8'h00) begin failures++; $display("FAIL mid_no_whack got=%h exp=00", whack); end
        end
        sw = 8'h00;
    endtask

    task automatic test_random();
        rst = 1'b1; step(); rst = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            rst      = ($urandom_range(0, 299) == 0);
            start    = ($urandom_range(0, 29) == 0);
            tick_1hz = ($urandom_range(0, 39) == 0);
            holes    = 8'($urandom);
            sw       = sw ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            step();
            checks++; if (act_v !== exp_v) begin failures++; $display("FAIL random c=%0d got=%h exp=%h", c, act_v, exp_v); end
        end
        rst = 1'b0; start = 1'b0; tick_1hz = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_bcd_carry_saturate();
        test_penalty();
        test_back_to_back();
        test_timer_over();
        test_reset_mid_game();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wam_score.md
Name: wam_score

Overview:
- Game-logic stage directly upstream of the digital-tube display driver.
- Detects player strikes on the 8 switches and judges each strike against the current mole pattern.
- Maintains a 3-digit packed-BCD score, a difficulty level and the game countdown.
- Drives score[11:0] and hrdn[3:0] into the display stage, and whack[7:0] back to the mole generator.

Parameters:
- GAME_SEC, 60: game length in seconds, legal range 1..99.
- PENALTY_EN, 1: when 1, striking an empty hole subtracts 1 from the score; when 0, it is ignored.

Ports:
- clk  input  1  system clock; every register updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a new game.
- tick_1hz  input  1  one-cycle pulse per second, synchronous to clk.
- holes  input  8  current mole pattern; bit i=1 means a mole is up in hole i.
- sw  input  8  debounced switch levels, already synchronous to clk.
- score  output  12  packed BCD score {hundreds, tens, ones}.
- hrdn  output  4  level digit for the display: 0 in IDLE, 1..4 in PLAY, 4'hF (blank) in OVER.
- whack  output  8  one-hot, one-cycle pulse: mole i has been hit and must be cleared.
- time_left  output  8  seconds remaining, binary.
- over  output  1  high while in the OVER state.

Behaviour:
- Reset values: state=IDLE, score=12'h000, hrdn=0, whack=0, time_left=GAME_SEC, over=0, pending=0, sw_q=sw sampled on the reset cycle.
  - Sampling sw into sw_q during reset prevents a false edge on the first cycle after reset.
- FSM states:
  - IDLE --start--> PLAY.
  - PLAY --(tick_1hz while time_left==1)--> OVER.
  - OVER --start--> PLAY.
  - start is ignored while in PLAY.
- Entering PLAY: on the same edge, score=0, pending=0, time_left=GAME_SEC.
- Timer:
  - In PLAY, each tick_1hz decrements time_left by 1.
  - The tick that takes time_left from 1 to 0 also moves the FSM to OVER.
  - time_left holds 0 in OVER and holds its value in IDLE.
- Strike detection:
  - sw_q<=sw every cycle in every state.
  - new = sw & ~sw_q, i.e. rising edges only.
  - In PLAY, pending <= (pending | new) & ~served.
  - Outside PLAY, pending is held at 0.
- Service: one strike per cycle.
  - served = one-hot of the lowest set bit of pending.
  - If holes[i]=1 for the served bit i: whack[i]=1 in the next cycle (registered, one-cycle pulse), and score increments on that same edge.
  - If holes[i]=0: no whack; if PENALTY_EN=1, score decrements.
  - Judging uses holes as sampled on the service cycle.
  - Latency: switch rising edge to score/whack update is 2 cycles when pending is empty.
  - Additional simultaneous strikes are served in ascending index order, one per cycle.
- BCD arithmetic:
  - Increment propagates a carry when a digit reaches 9 and rolls over to 0.
  - Score saturates at 12'h999; a hit at 999 still pulses whack.
  - Decrement propagates a borrow when a digit is at 0 and rolls it to 9.
  - Score floors at 12'h000.
  - Digits never take values A-F.
- Level (hrdn in PLAY), registered one cycle after score:
  - score[11:4]==0 -> 1.
  - score[11:4]==1 -> 2.
  - score[11:4]==2 or 3 -> 3.
  - Otherwise -> 4.
- Boundary conditions:
  - OVER: score is frozen and keeps displaying; pending is cleared on entry; a strike landing on the final tick cycle is discarded.
  - Switch held high: counts once; it must fall and rise again to strike again.
  - start and tick_1hz in the same cycle in IDLE/OVER: start wins and time_left=GAME_SEC.
  - rst mid-game: everything returns to the reset values on that edge.

Test Plan:
- Reset, start, holes=8'h04, raise sw[2] -> 2 cycles later whack=8'h04 for one cycle, score=12'h001, hrdn=1 one cycle after that.
- Score preset to 12'h009 via 9 hits, one more hit -> score=12'h010, hrdn=2; drive 990 hits total and continue -> score saturates at 12'h999, hrdn=4, whack still pulses.
- PENALTY_EN=1, score 12'h010, strike empty hole 0 -> score=12'h009, no whack; at 12'h000 an empty strike -> stays 12'h000.
- holes=8'hFF, sw rises 0->8'h81 in one cycle -> whack=8'h01 then 8'h80 on consecutive cycles, score +2.
- GAME_SEC=3, start, 3 tick_1hz -> time_left 3,2,1,0, over=1, hrdn=4'hF, further strikes leave score unchanged; start -> PLAY, score=0, time_left=3.
- Assert rst while pending=8'h0C in PLAY -> next cycle IDLE, score=0, whack=0, time_left=GAME_SEC, pending=0, no whack afterwards.
